// File: rtl/spectrum_peak_scanner.sv
// rtl/spectrum_peak_scanner.sv - FFT BRAM peak scanner sharing one read port with the display reader
// Finds the bin with the largest |re|+|im| over FIRST_BIN..LAST_BIN after each fft_done pulse.
module spectrum_peak_scanner #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 36,
  parameter int FIRST_BIN = 1,
  parameter int LAST_BIN  = 255,
  parameter int MAX_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fft_done,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd_en,
  input  logic                 mem_rd_valid,
  input  logic [DATA_W-1:0]    mem_data,
  input  logic                 disp_req,
  input  logic [ADDR_W-1:0]    disp_addr,
  output logic                 disp_grant,
  output logic                 disp_valid,
  output logic [DATA_W-1:0]    disp_data,
  output logic                 busy,
  output logic [ADDR_W-1:0]    peak_bin,
  output logic [DATA_W/2:0]    peak_mag,
  output logic                 peak_done,
  output logic                 overrun
);

  localparam int HALF_W = DATA_W / 2;
  localparam int MAG_W  = HALF_W + 1;
  localparam int CNT_W  = 3;

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_SCAN, S_DRAIN, S_DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0]  scan_addr_q, ret_bin_q, best_bin_q, peak_bin_q;
  logic [MAG_W-1:0]   best_mag_q, peak_mag_q;
  logic               busy_q, peak_done_q, overrun_q;

  logic               scan_rd, scan_ret, last_ret, take_best, cnt_dec;
  logic [HALF_W-1:0]  re_v, im_v, abs_re, abs_im;
  logic [MAG_W-1:0]   mag;

  always_comb begin
    disp_grant = (state_q == S_IDLE) && disp_req;
    scan_rd    = (state_q == S_SCAN) && (out_cnt_q != CNT_W'(MAX_OUT));
    mem_rd_en  = disp_grant || scan_rd;
    mem_addr   = '0;
    if (state_q == S_SCAN)
      mem_addr = scan_addr_q;
    else if (disp_grant)
      mem_addr = disp_addr;
  end

  // Before SCAN every outstanding read is a display read; HOLD keeps the two apart.
  assign disp_valid = mem_rd_valid && (out_cnt_q != '0) &&
                      ((state_q == S_IDLE) || (state_q == S_HOLD));
  assign disp_data  = mem_data;

  always_comb begin
    re_v     = mem_data[DATA_W-1:HALF_W];
    im_v     = mem_data[HALF_W-1:0];
    abs_re   = re_v[HALF_W-1] ? (~re_v + HALF_W'(1)) : re_v;
    abs_im   = im_v[HALF_W-1] ? (~im_v + HALF_W'(1)) : im_v;
    mag      = {1'b0, abs_re} + {1'b0, abs_im};
    scan_ret = mem_rd_valid && ((state_q == S_SCAN) || (state_q == S_DRAIN));
    last_ret = scan_ret && (ret_bin_q == ADDR_W'(LAST_BIN));
    take_best = scan_ret && ((ret_bin_q == ADDR_W'(FIRST_BIN)) || (mag > best_mag_q));
    cnt_dec  = mem_rd_valid && (out_cnt_q != '0);
    out_cnt_d = out_cnt_q;
    if (mem_rd_en && !cnt_dec)
      out_cnt_d = out_cnt_q + CNT_W'(1);
    else if (!mem_rd_en && cnt_dec)
      out_cnt_d = out_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      out_cnt_q   <= '0;
      scan_addr_q <= '0;
      ret_bin_q   <= '0;
      best_bin_q  <= '0;
      best_mag_q  <= '0;
      peak_bin_q  <= '0;
      peak_mag_q  <= '0;
      busy_q      <= 1'b0;
      peak_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_cnt_q   <= out_cnt_d;
      peak_done_q <= 1'b0;
      overrun_q   <= fft_done && (state_q != S_IDLE);
      if (take_best) begin
        best_bin_q <= ret_bin_q;
        best_mag_q <= mag;
      end
      if (scan_ret)
        ret_bin_q <= ret_bin_q + ADDR_W'(1);
      case (state_q)
        S_IDLE: begin
          if (fft_done) begin
            state_q <= S_HOLD;
            busy_q  <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_cnt_q == '0) begin
            state_q     <= S_SCAN;
            scan_addr_q <= ADDR_W'(FIRST_BIN);
            ret_bin_q   <= ADDR_W'(FIRST_BIN);
          end
        end
        S_SCAN: begin
          if (scan_rd) begin
            if (scan_addr_q == ADDR_W'(LAST_BIN))
              state_q <= S_DRAIN;
            else
              scan_addr_q <= scan_addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // The final return may itself be the new best, so bypass the best registers.
          if (last_ret) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            peak_done_q <= 1'b1;
            peak_bin_q  <= take_best ? ret_bin_q : best_bin_q;
            peak_mag_q  <= take_best ? mag : best_mag_q;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign peak_done = peak_done_q;
  assign overrun   = overrun_q;
  assign peak_bin  = peak_bin_q;
  assign peak_mag  = peak_mag_q;

endmodule
